// File: rtl/mio_responder_if.sv
// mio_if: core MEM-stage data port bundle between the core and the memory/IO responder.
interface mio_if;
  logic [31:0] addr_in;
  logic [31:0] data_w;
  logic        mem_w;
  logic [2:0]  dm_ctrl;
  logic [31:0] data_r;
  logic        mio_ready;
  modport master (output addr_in, data_w, mem_w, dm_ctrl, input data_r, mio_ready);
  modport slave  (input addr_in, data_w, mem_w, dm_ctrl, output data_r, mio_ready);
endinterface

// File: rtl/mio_responder.sv
// mio_responder: data RAM plus LED/switch/timer register window for the core's MEM-stage port.
module mio_responder #(
  parameter int RAM_WORDS = 1024,
  parameter int TIMER_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  mio_if.slave        bus,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        int_out,
  output logic        err_out
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0]        r_ram [RAM_WORDS];
  logic [TIMER_W-1:0] r_count, r_cmp;
  logic [15:0]        r_led;
  logic               r_en, r_pend, r_err, r_ready;
  logic               w_half, w_byte, w_word, w_mis, w_ram, w_per, w_match, w_pw, w_bad, w_cw, w_ctw;
  logic [2:0]         w_reg;
  logic [AW-1:0]      w_idx;
  logic [31:0]        w_rd, w_sh, w_ld, w_wd;
  logic [3:0]         w_be;
  always_comb begin
    w_half  = bus.dm_ctrl == 3'd1 || bus.dm_ctrl == 3'd2;
    w_byte  = bus.dm_ctrl == 3'd3 || bus.dm_ctrl == 3'd4;
    w_word  = !w_half && !w_byte;
    w_mis   = (w_word && bus.addr_in[1:0] != 2'b00) || (w_half && bus.addr_in[0]);
    w_ram   = bus.addr_in[31:AW+2] == '0;
    w_reg   = bus.addr_in[4:2];
    w_per   = bus.addr_in[31:5] == 27'h780_0000 && w_reg <= 3'd4;
    w_idx   = bus.addr_in[AW+1:2];
    w_rd    = w_ram ? r_ram[w_idx] : !w_per ? 32'h0 :
              w_reg == 3'd0 ? {16'h0, r_led} :
              w_reg == 3'd1 ? {16'h0, sw_in} :
              w_reg == 3'd2 ? 32'(r_count) :
              w_reg == 3'd3 ? 32'(r_cmp) : {30'h0, r_pend, r_en};
    w_sh    = w_rd >> {bus.addr_in[1:0], 3'b000};
    w_ld    = w_byte ? (bus.dm_ctrl == 3'd3 ? {{24{w_sh[7]}}, w_sh[7:0]} : {24'h0, w_sh[7:0]}) :
              w_half ? (bus.dm_ctrl == 3'd1 ? {{16{w_sh[15]}}, w_sh[15:0]} : {16'h0, w_sh[15:0]}) : w_sh;
    w_be    = w_word ? 4'hF : w_half ? (bus.addr_in[1] ? 4'hC : 4'h3) : 4'b0001 << bus.addr_in[1:0];
    w_wd    = w_word ? bus.data_w : w_half ? {2{bus.data_w[15:0]}} : {4{bus.data_w[7:0]}};
    w_match = r_en && r_count == r_cmp;
    w_pw    = bus.mem_w && w_per && w_word && !w_mis;
    w_cw    = w_pw && w_reg == 3'd2;
    w_ctw   = w_pw && w_reg == 3'd4;
    w_bad   = bus.mem_w && (w_mis || !(w_ram || w_per) || (w_per && !w_word));
  end
  assign bus.data_r    = (w_mis || !(w_ram || w_per)) ? 32'h0 : w_ld;
  assign bus.mio_ready = r_ready;
  assign led_out       = r_led;
  assign int_out       = r_pend;
  assign err_out       = r_err;
  // RAM is deliberately left out of reset so it maps onto block RAM with byte enables.
  always_ff @(posedge clk)
    if (bus.mem_w && w_ram && !w_mis)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_ram[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_led   <= 16'h0;
      r_count <= '0;
      r_cmp   <= '1;
      r_en    <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_bad) r_err <= 1'b1;
      if (w_pw && w_reg == 3'd0) r_led <= bus.data_w[15:0];
      if (w_pw && w_reg == 3'd3) r_cmp <= bus.data_w[TIMER_W-1:0];
      r_count <= w_cw ? bus.data_w[TIMER_W-1:0] : w_match ? '0 : r_en ? r_count + TIMER_W'(1) : r_count;
      // A match sets pending even when the same edge writes 1 to clear it.
      r_pend  <= w_match || (r_pend && !(w_ctw && bus.data_w[1]));
      if (w_ctw && !w_match) r_en <= bus.data_w[0];
    end
endmodule

// File: tb/tb_mio_responder.sv
// tb_mio_responder: directed plan steps plus randomized traffic against a byte-level reference model.
module tb_mio_responder;
  localparam int RW = 256;
  localparam int RB = RW * 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_in, led_out;
  logic        int_out, err_out;
  int          checks = 0, errors = 0;
  logic [7:0]  mem_m [RB];
  logic [15:0] led_m;
  logic [31:0] cnt_m, cmp_m;
  logic        en_m, pend_m, err_m;
  logic [31:0] keep, ra, rd;
  logic        rw;
  logic [2:0]  rc;
  int          rk;
  mio_if bus();
  mio_responder #(.RAM_WORDS(RW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sw_in(sw_in),
    .led_out(led_out), .int_out(int_out), .err_out(err_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int sz(input logic [2:0] c);
    return (c == 3'd1 || c == 3'd2) ? 2 : (c == 3'd3 || c == 3'd4) ? 1 : 4;
  endfunction
  function automatic bit is_per(input logic [31:0] a);
    return a >= 32'hF000_0000 && a <= 32'hF000_0013;
  endfunction
  function automatic logic [31:0] per_word(input logic [31:0] a);
    case (a[4:2])
      3'd0:    return {16'h0, led_m};
      3'd1:    return {16'h0, sw_in};
      3'd2:    return cnt_m;
      3'd3:    return cmp_m;
      default: return {30'h0, pend_m, en_m};
    endcase
  endfunction
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] c);
    int n;
    logic [31:0] v;
    n = sz(c);
    if (a % n != 0) return 32'h0;
    if (a < RB) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
    end else if (is_per(a)) v = per_word(a) >> (8 * (a % 4));
    else return 32'h0;
    if (n == 1) begin
      v = v & 32'hFF;
      if (c == 3'd3 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (c == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction
  task automatic model_reset();
    led_m = 16'h0; cnt_m = 32'h0; cmp_m = 32'hFFFF_FFFF; en_m = 1'b0; pend_m = 1'b0; err_m = 1'b0;
  endtask
  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] c);
    int n;
    bit match, cw, ctw;
    n = sz(c);
    match = en_m && cnt_m == cmp_m;
    cw = 0;
    ctw = 0;
    if (w) begin
      if (a % n != 0) err_m = 1'b1;
      else if (a < RB) for (int i = 0; i < n; i++) mem_m[a + i] = d[8*i +: 8];
      else if (is_per(a)) begin
        if (n != 4) err_m = 1'b1;
        else if (a[4:2] == 3'd0) led_m = d[15:0];
        else if (a[4:2] == 3'd2) cw = 1;
        else if (a[4:2] == 3'd3) cmp_m = d;
        else if (a[4:2] == 3'd4) ctw = 1;
      end else err_m = 1'b1;
    end
    cnt_m = cw ? d : match ? 32'h0 : en_m ? cnt_m + 32'h1 : cnt_m;
    if (match) pend_m = 1'b1;
    else if (ctw && d[1]) pend_m = 1'b0;
    if (ctw && !match) en_m = d[0];
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] c);
    bus.addr_in = a; bus.data_w = d; bus.mem_w = w; bus.dm_ctrl = c;
    #1 chk("load", bus.data_r, exp_load(a, c));
    model_edge(a, d, w, c);
    @(posedge clk);
    #1;
    bus.mem_w = 1'b0;
    chk("int", 32'(int_out), 32'(pend_m));
    chk("err", 32'(err_out), 32'(err_m));
    chk("led", 32'(led_out), 32'(led_m));
    chk("ready", 32'(bus.mio_ready), 32'h1);
  endtask
  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] c, input logic [31:0] exp);
    bus.addr_in = a; bus.mem_w = 1'b0; bus.dm_ctrl = c;
    #1;
    chk(tag, bus.data_r, exp);
    chk({tag, "_model"}, bus.data_r, exp_load(a, c));
  endtask
  initial begin
    bus.addr_in = 32'h0; bus.data_w = 32'h0; bus.mem_w = 1'b0; bus.dm_ctrl = 3'd0;
    sw_in = 16'h1234;
    model_reset();
    #3;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_int", 32'(int_out), 32'h0);
    chk("rst_err", 32'(err_out), 32'h0);
    chk("rst_ready", 32'(bus.mio_ready), 32'h0);
    ld("rst_sw", 32'hF000_0004, 3'd0, 32'h1234);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_low", 32'(bus.mio_ready), 32'h0);
    @(posedge clk);
    #1 chk("ready_high", 32'(bus.mio_ready), 32'h1);
    for (int i = 0; i < RW; i++) begin
      bus.addr_in = 32'(i * 4); bus.data_w = $urandom; bus.mem_w = 1'b1; bus.dm_ctrl = 3'd0;
      model_edge(bus.addr_in, bus.data_w, 1'b1, 3'd0);
      @(posedge clk);
      #1;
    end
    bus.mem_w = 1'b0;
    op(32'h10, 32'h1234_5678, 1'b1, 3'd0);
    op(32'h11, 32'h0000_00AB, 1'b1, 3'd3);
    ld("lw10", 32'h10, 3'd0, 32'h1234_AB78);
    ld("lb11", 32'h11, 3'd3, 32'hFFFF_FFAB);
    ld("lbu11", 32'h11, 3'd4, 32'h0000_00AB);
    keep = exp_load(32'h20, 3'd2);
    op(32'h22, 32'h0000_8001, 1'b1, 3'd1);
    ld("lh22", 32'h22, 3'd1, 32'hFFFF_8001);
    ld("lhu22", 32'h22, 3'd2, 32'h0000_8001);
    ld("lw20", 32'h20, 3'd0, {16'h8001, keep[15:0]});
    op(32'h13, 32'hDEAD_BEEF, 1'b1, 3'd0);
    chk("mis_err", 32'(err_out), 32'h1);
    ld("lw13", 32'h13, 3'd0, 32'h0);
    ld("lw10_keep", 32'h10, 3'd0, 32'h1234_AB78);
    sw_in = 16'hBEEF;
    ld("sw", 32'hF000_0004, 3'd0, 32'h0000_BEEF);
    op(32'hF000_0000, 32'h0001_5A5A, 1'b1, 3'd0);
    chk("led_5a5a", 32'(led_out), 32'h5A5A);
    op(32'hF000_000C, 32'h4, 1'b1, 3'd0);
    op(32'hF000_0010, 32'h1, 1'b1, 3'd0);
    for (int k = 1; k <= 5; k++) begin
      op(32'h0, 32'h0, 1'b0, 3'd0);
      chk("int_rise", 32'(int_out), 32'(k == 5));
    end
    ld("cnt_wrap", 32'hF000_0008, 3'd0, 32'h0);
    op(32'hF000_0010, 32'h2, 1'b1, 3'd0);
    chk("int_clear", 32'(int_out), 32'h0);
    op(32'hF000_0010, 32'h1, 1'b1, 3'd0);
    repeat (3) op(32'h0, 32'h0, 1'b0, 3'd0);
    chk("int_before", 32'(int_out), 32'h0);
    op(32'hF000_0010, 32'h3, 1'b1, 3'd0);
    chk("set_wins", 32'(int_out), 32'h1);
    op(32'hF000_0008, 32'd100, 1'b1, 3'd0);
    ld("cnt100", 32'hF000_0008, 3'd0, 32'd100);
    op(32'h0, 32'h0, 1'b0, 3'd0);
    ld("cnt101", 32'hF000_0008, 3'd0, 32'd101);
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_led", 32'(led_out), 32'h0);
    chk("arst_int", 32'(int_out), 32'h0);
    chk("arst_err", 32'(err_out), 32'h0);
    chk("arst_ready", 32'(bus.mio_ready), 32'h0);
    ld("arst_ram", 32'h10, 3'd0, 32'h1234_AB78);
    ld("arst_cmp", 32'hF000_000C, 3'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_again", 32'(bus.mio_ready), 32'h1);
    repeat (400) begin
      rk = $urandom_range(0, 9);
      rc = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      rd = $urandom;
      if (rk < 7) ra = 32'($urandom_range(0, RB - 1));
      else if (rk < 9) begin
        ra = 32'hF000_0000 + 32'(4 * $urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) ra = ra + 32'($urandom_range(1, 3));
        rd = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) rc = 3'd0;
      end else ra = $urandom | 32'h0001_0000;
      if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
      op(ra, rd, rw, rc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mio_responder.md
# mio_responder

Memory/IO responder for the pipelined RISC-V core's MEM-stage data port. It decodes each core access into either a word-organised data RAM or a small peripheral register window containing LEDs, switches and a compare timer. Loads are answered combinationally in the same cycle. Stores commit on the rising clock edge with byte-lane merging. The timer raises a level interrupt that feeds the core's INT input.

## Interface
Parameters:
- RAM_WORDS, 1024: data RAM depth in 32-bit words; power of two.
- TIMER_W, 32: timer counter width; ≤ 32; upper read bits zero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr_in  in  32  byte address from core (EX/MEM ALU result).
- data_w  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- mem_w  in  1  store strobe for current cycle.
- dm_ctrl  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes treated as word.
- data_r  out  32  load data, extended per dm_ctrl; combinational.
- mio_ready  out  1  responder ready.
- sw_in  in  16  board switches.
- led_out  out  16  LED register.
- int_out  out  1  timer interrupt, level.
- err_out  out  1  sticky misaligned/unmapped-store flag.

## Operation
- Address map:
  - 0x0000_0000 .. RAM_WORDS*4-1: RAM, word index addr_in[log2(RAM_WORDS)+1:2].
  - 0xF000_0000: LED, RW, low 16 bits.
  - 0xF000_0004: switches, RO, zero-extended sw_in.
  - 0xF000_0008: timer count, RW.
  - 0xF000_000C: timer compare, RW.
  - 0xF000_0010: control. Bit0 enable, RW. Bit1 pending, write-1-to-clear.
  - Anything else is unmapped.
- Alignment:
  - Word accesses need addr_in[1:0]=00.
  - Half accesses need addr_in[0]=0.
  - Bytes are always aligned.
- Load path:
  - Select the addressed word.
  - Extract the lane: byte at addr_in[1:0]; half at addr_in[1] (0 = bits[15:0]).
  - Sign- or zero-extend per dm_ctrl.
  - Misaligned or unmapped loads return 0. No state change.
- RAM store (mem_w=1, aligned):
  - Write only the selected lanes: byte writes 1 lane, half writes 2, word writes 4.
  - Untouched lanes keep their value.
- Peripheral store:
  - Only word stores take effect. Sub-word stores to peripherals are ignored and set err_out.
  - The switch register ignores writes; no error.
- Misaligned or unmapped store: write suppressed; err_out←1 until reset.
- Timer:
  - While enable=1, count increments each cycle.
  - When count==compare at a rising edge: count←0 and pending←1.
  - int_out = pending.
- Priority on the same edge:
  - A core write to count overrides increment and wrap.
  - A match sets pending even if the same cycle writes 1 to clear it (set wins).
  - A control write updates enable and clears pending only if no match occurs.
- RAM contents are not reset. All registers are reset.

## Timing
- Reset values:
  - Outputs: led_out=0, int_out=0, err_out=0, mio_ready=0.
  - Registers: count=0, compare=0xFFFF_FFFF (truncated to TIMER_W), enable=0.
  - data_r tracks its inputs even during reset; RAM reads are valid during reset.
- mio_ready rises 1 cycle after rst deasserts and stays 1. Reset asserted mid-operation drops it immediately (asynchronous).
- Load latency is 0 cycles: data_r is valid in the same cycle as addr_in/dm_ctrl, ahead of the core's MEM/WB capture edge.
- Stores are visible to a load at the same address in the cycle after the write edge. A same-cycle read returns the old data.
- Register read-after-write follows the same rule. A pending set by a match is visible on int_out one cycle after the edge.
- Count wraps naturally at 2^TIMER_W−1 → 0 if compare is unreachable.

## Test plan
- Store word 0x1234_5678 at 0x10, then sb 0xAB at 0x11 → next-cycle lw 0x10 returns 0x1234_AB78; lb 0x11 returns 0xFFFF_FFAB; lbu 0x11 returns 0x0000_00AB.
- sh 0x8001 at 0x22, then lh 0x22 → 0xFFFF_8001; lhu 0x22 → 0x0000_8001; lw 0x20 has bits[15:0] unchanged.
- sw at 0x13 → RAM unchanged, err_out=1 next cycle; lw 0x13 returns 0.
- Write compare=4, then control=1 → int_out rises exactly 5 cycles after the enable edge; count reads 0 then. Write control=2 → int_out falls next cycle.
- In the same cycle as a compare match, write control=3 → pending stays 1. A separate write to count=100 while running → next read of count is 100, or 101 if read one cycle later.
- sw_in=0xBEEF, lw 0xF000_0004 → 0x0000_BEEF. sw 0x1_5A5A to 0xF000_0000 → led_out=0x5A5A. Assert rst mid-run → led_out, int_out, err_out and mio_ready go to 0 immediately.
